hazard_ctrl_unit: RTL and testbench

Parametrised hazard controller for the 3-stage RV32I pipeline (FD, EM, MW) that replaces the combinational forwarding/flush logic. Generates MW->EM operand forwarding with x0 and operand-use qualification, inserts multi-cycle load-use stalls, holds the pipeline during data-memory wait states, and stretches branch flushes over a configurable number of cycles. Sits beside the datapath, driving the PC/FD/EM/MW register enables and the EM forwarding muxes. Also keeps saturating stall/flush event counters for performance monitoring.

---
 rtl/hazard_ctrl_unit.sv | 181 ++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// ============================================================================
//  hazard_ctrl_unit
//  Forwarding, load-use stall, memory-wait hold and branch-flush control for
//  a 3-stage RV32I pipeline, with saturating stall/flush event counters.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl_unit #(
  parameter int Width        = 32,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_wrMW,
  input  logic             is_loadMW,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             br_taken,
  input  logic [Width-1:0] ir_EM,
  input  logic [Width-1:0] ir_MW,
  output logic             fora,
  output logic             forb,
  output logic             stall,
  output logic             stall_MW,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int c_cnt_max = (LOAD_LAT > FLUSH_CYCLES) ? LOAD_LAT : FLUSH_CYCLES;
  localparam int c_cw      = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

  localparam logic [c_cw-1:0]  c_load_init  = c_cw'(LOAD_LAT - 1);
  localparam logic [c_cw-1:0]  c_flush_init = c_cw'(FLUSH_CYCLES - 1);
  localparam logic [c_cw-1:0]  c_cnt_one    = c_cw'(1);
  localparam logic             c_load_en    = (LOAD_LAT > 0);
  localparam logic [CNT_W-1:0] c_inc        = CNT_W'(1);

  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_WAIT = 2'd1,
    FLUSH     = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_cw-1:0] r_cnt, w_cnt_nxt;
  logic            r_served, w_served_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic [4:0] w_rs1, w_rs2, w_rd_mw;
  logic [6:0] w_op_em;
  logic       w_use_rs1, w_use_rs2;
  logic       w_match_a, w_match_b;
  logic       w_mem_wait, w_load_haz;
  logic       w_stall, w_stall_mw, w_flush;

  wire w_unused_bits = &{1'b0, ir_EM[Width-1:25], ir_EM[14:7],
                         ir_MW[Width-1:12], ir_MW[6:0]};

  assign w_rs1   = ir_EM[19:15];
  assign w_rs2   = ir_EM[24:20];
  assign w_rd_mw = ir_MW[11:7];
  assign w_op_em = ir_EM[6:0];

  // Only real source operands may trigger forwarding or a load-use stall.
  assign w_use_rs1 = (w_op_em != c_op_lui) && (w_op_em != c_op_auipc) &&
                     (w_op_em != c_op_jal);
  assign w_use_rs2 = (w_op_em == c_op_rtype) || (w_op_em == c_op_store) ||
                     (w_op_em == c_op_branch);

  assign w_match_a = reg_wrMW && (w_rd_mw != 5'd0) && (w_rd_mw == w_rs1) && w_use_rs1;
  assign w_match_b = reg_wrMW && (w_rd_mw != 5'd0) && (w_rd_mw == w_rs2) && w_use_rs2;

  assign w_mem_wait = mem_req && !mem_ready;
  assign w_load_haz = is_loadMW && (w_match_a || w_match_b) && c_load_en &&
                      !r_served && (r_state == RUN);

  always_comb begin
    w_stall      = 1'b0;
    w_stall_mw   = 1'b0;
    w_flush      = 1'b0;
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_served_nxt = r_served;
    if (w_mem_wait) begin
      // Whole pipeline frozen; an in-progress flush keeps its bubbles.
      w_stall    = 1'b1;
      w_stall_mw = 1'b1;
      w_flush    = (r_state == FLUSH);
    end else begin
      case (r_state)
        RUN: begin
          w_served_nxt = 1'b0;
          if (w_load_haz) begin
            w_stall    = 1'b1;
            w_stall_mw = 1'b1;
            if (LOAD_LAT > 1) begin
              w_state_nxt = LOAD_WAIT;
              w_cnt_nxt   = c_load_init;
            end else begin
              w_served_nxt = 1'b1;
            end
          end else if (br_taken) begin
            w_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_state_nxt = FLUSH;
              w_cnt_nxt   = c_flush_init;
            end
          end
        end
        LOAD_WAIT: begin
          w_stall      = 1'b1;
          w_stall_mw   = 1'b1;
          w_served_nxt = 1'b0;
          w_cnt_nxt    = r_cnt - c_cnt_one;
          if (r_cnt == c_cnt_one) begin
            w_state_nxt  = RUN;
            w_served_nxt = 1'b1;
          end
        end
        FLUSH: begin
          w_flush      = 1'b1;
          w_served_nxt = 1'b0;
          w_cnt_nxt    = r_cnt - c_cnt_one;
          if (r_cnt == c_cnt_one) begin
            w_state_nxt = RUN;
          end
        end
        default: begin
          w_state_nxt  = RUN;
          w_cnt_nxt    = '0;
          w_served_nxt = 1'b0;
        end
      endcase
    end
  end

  assign fora     = w_match_a  && !rst;
  assign forb     = w_match_b  && !rst;
  assign stall    = w_stall    && !rst;
  assign stall_MW = w_stall_mw && !rst;
  assign flush    = w_flush    && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_served <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_served <= w_served_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + c_inc;
      if (flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + c_inc;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
// ============================================================================
//  tb_hazard_ctrl_unit
//  Directed bench: instance a (LOAD_LAT=3, FLUSH_CYCLES=2, CNT_W=16) and
//  instance b (LOAD_LAT=2, FLUSH_CYCLES=1, CNT_W=4) share one stimulus bus.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst, reg_wrMW, is_loadMW, mem_req, mem_ready, br_taken;
  logic [31:0] ir_EM, ir_MW;

  logic        fora_a, forb_a, stall_a, stall_mw_a, flush_a;
  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic        fora_b, forb_b, stall_b, stall_mw_b, flush_b;
  logic [3:0]  stall_cnt_b, flush_cnt_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.Width(32), .LOAD_LAT(3), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .reg_wrMW(reg_wrMW), .is_loadMW(is_loadMW),
    .mem_req(mem_req), .mem_ready(mem_ready), .br_taken(br_taken),
    .ir_EM(ir_EM), .ir_MW(ir_MW), .fora(fora_a), .forb(forb_a),
    .stall(stall_a), .stall_MW(stall_mw_a), .flush(flush_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  hazard_ctrl_unit #(.Width(32), .LOAD_LAT(2), .FLUSH_CYCLES(1), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .reg_wrMW(reg_wrMW), .is_loadMW(is_loadMW),
    .mem_req(mem_req), .mem_ready(mem_ready), .br_taken(br_taken),
    .ir_EM(ir_EM), .ir_MW(ir_MW), .fora(fora_b), .forb(forb_b),
    .stall(stall_b), .stall_MW(stall_mw_b), .flush(flush_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] lw_ins(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    reg_wrMW  = 1'b0;
    is_loadMW = 1'b0;
    mem_req   = 1'b0;
    mem_ready = 1'b0;
    br_taken  = 1'b0;
    ir_EM     = 32'd0;
    ir_MW     = 32'd0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_load_use;
    reg_wrMW  = 1'b1;
    is_loadMW = 1'b1;
    ir_MW     = lw_ins(5'd7, 5'd1);
    ir_EM     = r_type(5'd8, 5'd7, 5'd1);
  endtask

  task automatic test_reset;
    clear_inputs();
    rst      = 1'b1;
    reg_wrMW = 1'b1;
    br_taken = 1'b1;
    ir_MW    = r_type(5'd5, 5'd1, 5'd2);
    ir_EM    = r_type(5'd6, 5'd5, 5'd5);
    #1;
    n_checks++; if (fora_a !== 1'b0) $display("FAIL rst_fora actual=%b expected=0", fora_a); else n_pass++;
    n_checks++; if (flush_a !== 1'b0) $display("FAIL rst_flush actual=%b expected=0", flush_a); else n_pass++;
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    n_checks++; if (stall_cnt_a !== 16'd0) $display("FAIL rst_stall_cnt actual=%0d expected=0", stall_cnt_a); else n_pass++;
    n_checks++; if (flush_cnt_a !== 16'd0) $display("FAIL rst_flush_cnt actual=%0d expected=0", flush_cnt_a); else n_pass++;
    n_checks++; if (stall_a !== 1'b0) $display("FAIL rst_stall actual=%b expected=0", stall_a); else n_pass++;
  endtask

  task automatic test_forward;
    do_reset();
    reg_wrMW = 1'b1;
    ir_MW    = r_type(5'd5, 5'd1, 5'd2);
    ir_EM    = r_type(5'd6, 5'd5, 5'd5);
    #1;
    n_checks++; if (fora_a !== 1'b1) $display("FAIL fwd_fora actual=%b expected=1", fora_a); else n_pass++;
    n_checks++; if (forb_a !== 1'b1) $display("FAIL fwd_forb actual=%b expected=1", forb_a); else n_pass++;
    n_checks++; if (stall_a !== 1'b0) $display("FAIL fwd_stall actual=%b expected=0", stall_a); else n_pass++;
    ir_MW = r_type(5'd0, 5'd1, 5'd2);
    ir_EM = r_type(5'd6, 5'd0, 5'd0);
    #1;
    n_checks++; if ({fora_a, forb_a} !== 2'b00) $display("FAIL fwd_x0 actual=%b expected=00", {fora_a, forb_a}); else n_pass++;
    ir_MW = r_type(5'd5, 5'd1, 5'd2);
    ir_EM = {12'd0, 5'd5, 3'd0, 5'd9, 7'b0110111};
    #1;
    n_checks++; if ({fora_a, forb_a} !== 2'b00) $display("FAIL fwd_lui actual=%b expected=00", {fora_a, forb_a}); else n_pass++;
    ir_EM = {7'd0, 5'd5, 5'd5, 3'd0, 5'd6, 7'b0010011};
    #1;
    n_checks++; if ({fora_a, forb_a} !== 2'b10) $display("FAIL fwd_addi actual=%b expected=10", {fora_a, forb_a}); else n_pass++;
    reg_wrMW = 1'b0;
    #1;
    n_checks++; if (fora_a !== 1'b0) $display("FAIL fwd_nowr actual=%b expected=0", fora_a); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_load_use;
    do_reset();
    set_load_use();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({stall_a, stall_mw_a, flush_a} !== 3'b110) $display("FAIL lu_stall%0d actual=%b expected=110", i, {stall_a, stall_mw_a, flush_a}); else n_pass++;
      tick();
    end
    #1;
    n_checks++; if ({stall_a, fora_a, forb_a} !== 3'b010) $display("FAIL lu_release actual=%b expected=010", {stall_a, fora_a, forb_a}); else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_checks++; if (stall_cnt_a !== 16'd3) $display("FAIL lu_stall_cnt actual=%0d expected=3", stall_cnt_a); else n_pass++;
  endtask

  task automatic test_branch;
    do_reset();
    br_taken = 1'b1;
    #1;
    n_checks++; if ({flush_a, stall_a} !== 2'b10) $display("FAIL br_c1 actual=%b expected=10", {flush_a, stall_a}); else n_pass++;
    tick();
    #1;
    n_checks++; if (flush_a !== 1'b1) $display("FAIL br_c2 actual=%b expected=1", flush_a); else n_pass++;
    tick();
    br_taken = 1'b0;
    #1;
    n_checks++; if (flush_a !== 1'b0) $display("FAIL br_c3 actual=%b expected=0", flush_a); else n_pass++;
    n_checks++; if (flush_cnt_a !== 16'd2) $display("FAIL br_flush_cnt actual=%0d expected=2", flush_cnt_a); else n_pass++;
  endtask

  task automatic test_mem_wait;
    do_reset();
    set_load_use();
    #1;
    n_checks++; if (stall_b !== 1'b1) $display("FAIL mw_first actual=%b expected=1", stall_b); else n_pass++;
    tick();
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if ({stall_b, stall_mw_b} !== 2'b11) $display("FAIL mw_hold%0d actual=%b expected=11", i, {stall_b, stall_mw_b}); else n_pass++;
      tick();
    end
    mem_req = 1'b0;
    #1;
    n_checks++; if (stall_b !== 1'b1) $display("FAIL mw_last actual=%b expected=1", stall_b); else n_pass++;
    tick();
    #1;
    n_checks++; if ({stall_b, fora_b} !== 2'b01) $display("FAIL mw_release actual=%b expected=01", {stall_b, fora_b}); else n_pass++;
    n_checks++; if (stall_cnt_b !== 4'd6) $display("FAIL mw_stall_cnt actual=%0d expected=6", stall_cnt_b); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_back_to_back;
    do_reset();
    br_taken = 1'b1;
    #1;
    n_checks++; if (flush_a !== 1'b1) $display("FAIL fw_c1 actual=%b expected=1", flush_a); else n_pass++;
    tick();
    br_taken = 1'b0;
    mem_req  = 1'b1;
    #1;
    n_checks++; if ({flush_a, stall_a} !== 2'b11) $display("FAIL fw_wait actual=%b expected=11", {flush_a, stall_a}); else n_pass++;
    tick();
    mem_req = 1'b0;
    #1;
    n_checks++; if ({flush_a, stall_a} !== 2'b10) $display("FAIL fw_c2 actual=%b expected=10", {flush_a, stall_a}); else n_pass++;
    tick();
    #1;
    n_checks++; if (flush_a !== 1'b0) $display("FAIL fw_done actual=%b expected=0", flush_a); else n_pass++;
    n_checks++; if (flush_cnt_a !== 16'd3) $display("FAIL fw_flush_cnt actual=%0d expected=3", flush_cnt_a); else n_pass++;
  endtask

  task automatic test_conflict_reset;
    do_reset();
    set_load_use();
    br_taken = 1'b1;
    #1;
    n_checks++; if ({stall_a, flush_a} !== 2'b10) $display("FAIL cf_prio actual=%b expected=10", {stall_a, flush_a}); else n_pass++;
    tick();
    rst = 1'b1;
    #1;
    n_checks++; if ({stall_a, stall_mw_a, flush_a, fora_a, forb_a} !== 5'b00000) $display("FAIL cf_rst_outs actual=%b expected=00000", {stall_a, stall_mw_a, flush_a, fora_a, forb_a}); else n_pass++;
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    n_checks++; if (stall_a !== 1'b0) $display("FAIL cf_run actual=%b expected=0", stall_a); else n_pass++;
    n_checks++; if ({stall_cnt_a, flush_cnt_a} !== 32'd0) $display("FAIL cf_cnts actual=%h expected=0", {stall_cnt_a, flush_cnt_a}); else n_pass++;
  endtask

  task automatic test_saturation;
    do_reset();
    mem_req = 1'b1;
    repeat (20) tick();
    clear_inputs();
    #1;
    n_checks++; if (stall_cnt_b !== 4'd15) $display("FAIL sat_b actual=%0d expected=15", stall_cnt_b); else n_pass++;
    n_checks++; if (stall_cnt_a !== 16'd20) $display("FAIL sat_a actual=%0d expected=20", stall_cnt_a); else n_pass++;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_back_to_back();
    test_conflict_reset();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
